// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Writeback arbiter in front of a 32x16 register file with a single write port.
// Two producers share that port:
//   - ALU path: single-cycle results. They win whenever they are accepted.
//   - mem/MAC path: variable-latency results, queued in a small FIFO. Entries
//     drain in acceptance order whenever the ALU does not claim the port.
// A starvation FSM forces one FIFO drain after STARVE_LIMIT consecutive ALU
// wins while the FIFO holds data. pending_mask shows which registers still
// have writes queued, so the issue stage can avoid RAW hazards.
//
// Optional feature: define WB_BYPASS_EN to enable the empty-FIFO bypass. With
// the bypass, a mem result goes straight to the write register when the ALU
// is idle and the FIFO is empty.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_ready             ALU result handshake
//   alu_addr/alu_data               ALU destination register and value
//   mem_valid/mem_ready             mem result handshake (FIFO input)
//   mem_addr/mem_data               mem destination register and value
//   write_en/write_addr/write_data  registered register-file write port
//   fifo_count                      current FIFO occupancy
//   pending_mask                    one bit per register targeted by a FIFO entry
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int REG_DEPTH    = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic [REG_DEPTH-1:0]  pending_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [STV_W-1:0]     STV_LAST  = STV_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    NORMAL      = 1'b0,
    FORCE_DRAIN = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [STV_W-1:0]     starve_cnt, starve_nxt;

  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

  logic fifo_empty;
  logic alu_xfer;
  logic mem_xfer;
  logic bypass;
  logic pop;
  logic push;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);

  // Readiness uses only registered state. There is no same-cycle
  // pass-through when the FIFO is full.
  assign alu_ready = !rst && (state == NORMAL);
  assign mem_ready = !rst && (count < FULL_CNT);

  assign alu_xfer = alu_valid && alu_ready;
  assign mem_xfer = mem_valid && mem_ready;

`ifdef WB_BYPASS_EN
  // An idle port with an empty FIFO lets the mem result skip the queue.
  assign bypass = mem_xfer && !alu_xfer && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // The ALU blocks only the FIFO head. In FORCE_DRAIN the ALU is held off,
  // so the head pops.
  assign pop  = !alu_xfer && !fifo_empty;
  assign push = mem_xfer && !bypass;

  // Starvation FSM: next state and counter
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      NORMAL: begin
        if (fifo_empty || pop) begin
          starve_nxt = '0;
        end else if (alu_xfer) begin
          if (starve_cnt == STV_LAST) begin
            state_nxt  = FORCE_DRAIN;
            starve_nxt = '0;
          end else begin
            starve_nxt = starve_cnt + STV_W'(1);
          end
        end
      end
      FORCE_DRAIN: begin
        state_nxt  = NORMAL;
        starve_nxt = '0;
      end
      default: begin
        state_nxt  = NORMAL;
        starve_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // FIFO control: pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
    end
  end

  // FIFO storage: payload only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // An entry is live if its distance from the read pointer is below the count
  always_comb begin
    logic [PTR_W-1:0] off;
    pending_mask = '0;
    off          = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_WIDTH'(off) < count) pending_mask[fifo_addr[i]] = 1'b1;
    end
  end

  // Write-port register stage: priority ALU > FIFO head > bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= alu_xfer || pop || bypass;
      if (alu_xfer) begin
        write_addr <= alu_addr;
        write_data <= alu_data;
      end else if (pop) begin
        write_addr <= fifo_addr[rd_ptr];
        write_data <= fifo_data[rd_ptr];
      end else if (bypass) begin
        write_addr <= mem_addr;
        write_data <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_arbiter. A queue-based reference model tracks the
// FIFO contents, the starvation count and the expected write port every cycle.
// Directed scenarios and randomized traffic are checked against that model.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [15:0] write_data;
  logic [2:0]  fifo_count;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .fifo_count(fifo_count), .pending_mask(pending_mask)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } item_t;

  item_t       q[$];
  int          starve = 0;
  bit          force_drain = 0;
  logic        m_wen = 0;
  logic [4:0]  m_waddr = 0;
  logic [15:0] m_wdata = 0;
  bit          last_alu_x = 0;
  bit          last_mem_x = 0;

  // One clock: inputs are already set at a negedge. Check the combinational
  // outputs, let the edge happen, advance the model, then check the write port.
  task automatic step();
    int          sz;
    bit          ar, mr, ax, mx, byp, popped;
    logic [31:0] pm;
    item_t       it;
    #1;
    sz = q.size();
    ar = !rst && !force_drain;
    mr = !rst && (sz < 4);
    pm = 0;
    foreach (q[k]) pm[q[k].a] = 1'b1;
    chk("alu_ready", 32'(alu_ready), 32'(ar));
    chk("mem_ready", 32'(mem_ready), 32'(mr));
    chk("fifo_count", 32'(fifo_count), 32'(sz));
    chk("pending_mask", pending_mask, pm);
    ax  = alu_valid && ar;
    mx  = mem_valid && mr;
    byp = BYP && mx && !ax && (sz == 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0; force_drain = 0;
      m_wen = 0; m_waddr = 0; m_wdata = 0;
      ax = 0; mx = 0;
    end else begin
      popped = 0;
      m_wen  = 1;
      if (ax) begin
        m_waddr = alu_addr; m_wdata = alu_data;
      end else if (sz > 0) begin
        it = q.pop_front();
        m_waddr = it.a; m_wdata = it.d; popped = 1;
      end else if (byp) begin
        m_waddr = mem_addr; m_wdata = mem_data;
      end else begin
        m_wen = 0;
      end
      if (mx && !byp) q.push_back('{mem_addr, mem_data});
      if (force_drain) begin
        force_drain = 0; starve = 0;
      end else if (sz == 0 || popped) begin
        starve = 0;
      end else if (ax) begin
        starve++;
        if (starve == 8) begin
          force_drain = 1; starve = 0;
        end
      end
    end
    last_alu_x = ax;
    last_mem_x = mx;
    #1;
    chk("write_en", 32'(write_en), 32'(m_wen));
    chk("write_addr", 32'(write_addr), 32'(m_waddr));
    chk("write_data", 32'(write_data), 32'(m_wdata));
    @(negedge clk);
  endtask

  initial begin
    int  next_mem;
    bit  seen;
    rst = 1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    @(negedge clk);

    // Reset held for two cycles, then released
    step(); step();
    rst = 0;
    step();
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);

    // Single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 16'h1234;
    step();
    chk("alu_wr_en", 32'(write_en), 1);
    chk("alu_wr_addr", 32'(write_addr), 5);
    chk("alu_wr_data", 32'(write_data), 32'h1234);
    alu_valid = 0;
    step();
    chk("alu_wr_pulse", 32'(write_en), 0);

    // Fill and backpressure, continuing into a starvation drain
    alu_valid = 1; alu_addr = 0; alu_data = 16'h00AA;
    mem_valid = 1; next_mem = 1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      mem_addr = 5'(next_mem); mem_data = 16'(16'h0100 + next_mem);
      step();
      if (last_mem_x) begin
        next_mem++;
        if (next_mem == 5) begin
          chk("fill_count", 32'(fifo_count), 4);
          chk("fill_mask", pending_mask, 32'h0000001E);
          chk("fill_mem_ready", 32'(mem_ready), 0);
        end
      end
      mem_addr = 5'(next_mem); mem_data = 16'(16'h0100 + next_mem);
      if (!alu_ready) begin
        seen = 1;
        step();
        chk("drain_addr", 32'(write_addr), 1);
        chk("drain_count", 32'(fifo_count), 3);
        chk("drain_mask", pending_mask, 32'h0000001C);
        chk("drain_alu_ready", 32'(alu_ready), 1);
      end
    end
    if (!seen) chk("starve_seen", 0, 1);
    alu_valid = 0; mem_valid = 0;
    repeat (7) step();

    // Same-register ordering on the mem path
    mem_valid = 1; mem_addr = 7; mem_data = 16'h000A;
    step();
    chk("ord_first_latency", 32'(write_en), 32'(BYP));
    mem_data = 16'h000B;
    step();
    chk("ord_second", 32'(write_data), BYP ? 32'h000B : 32'h000A);
    mem_valid = 0;
    step();
    chk("ord_last", 32'(write_data), 32'h000B);
    step();

    // Reset with three entries queued
    alu_valid = 1; alu_addr = 0; alu_data = 16'h0055;
    mem_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mem_addr = 5'(3 + i); mem_data = 16'(i);
      step();
    end
    chk("mid_count", 32'(fifo_count), 3);
    alu_valid = 0; mem_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_mask", pending_mask, 0);
    repeat (4) step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!alu_valid || last_alu_x) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_addr  = 5'($urandom);
        alu_data  = 16'($urandom);
      end
      if (!mem_valid || last_mem_x) begin
        mem_valid = ($urandom_range(0, 1) == 1);
        mem_addr  = 5'($urandom);
        mem_data  = 16'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
